// File: rtl/noc_pkg.sv
// Shared NoC router definitions: port codes, flit type codes, routing algorithm
// selectors and the RCU state encoding.
package noc_pkg;

  typedef logic [2:0] port_t;
  typedef logic [1:0] flit_type_t;
  typedef logic [1:0] rcu_state_t;

  localparam port_t PORT_NONE  = 3'b000;
  localparam port_t PORT_LOCAL = 3'b001;
  localparam port_t PORT_EAST  = 3'b010;
  localparam port_t PORT_WEST  = 3'b011;
  localparam port_t PORT_NORTH = 3'b100;
  localparam port_t PORT_SOUTH = 3'b101;
  localparam port_t PORT_UP    = 3'b110;
  localparam port_t PORT_DOWN  = 3'b111;

  localparam flit_type_t FLIT_HEAD = 2'b11;
  localparam flit_type_t FLIT_BODY = 2'b10;
  localparam flit_type_t FLIT_TAIL = 2'b01;
  localparam flit_type_t FLIT_BAD  = 2'b00;

  localparam int ALGO_XY = 0;
  localparam int ALGO_YX = 1;
  localparam int ALGO_WF = 2;

  // Bit positions inside the {S,N,W,E} congestion vector
  localparam int CONG_E = 0;
  localparam int CONG_W = 1;
  localparam int CONG_N = 2;
  localparam int CONG_S = 3;

  localparam rcu_state_t ST_IDLE = 2'd0;
  localparam rcu_state_t ST_HEAD = 2'd1;
  localparam rcu_state_t ST_BODY = 2'd2;

endpackage

// File: rtl/rcu_param_if.sv
// Link between the input VC buffer / switch allocator (master) and the
// routing computation unit (slave).
interface rcu_param_if #(
  parameter int FW = 39
) ();

  logic [FW:0] flit;
  logic        flit_valid;
  logic        flit_ack;
  logic [3:0]  cong;
  logic [2:0]  op;
  logic        op_valid;
  logic        err;

  modport master (
    output flit, flit_valid, flit_ack, cong,
    input  op, op_valid, err
  );

  modport slave (
    input  flit, flit_valid, flit_ack, cong,
    output op, op_valid, err
  );

endinterface

// File: rtl/rcu_route_calc.sv
// Combinational route function: destination coordinates plus congestion
// flags to an output port code (XY, YX or west-first, optional Z dimension).
module rcu_route_calc
  import noc_pkg::*;
#(
  parameter int CW   = 4,
  parameter int MY_X = 0,
  parameter int MY_Y = 0,
  parameter int MY_Z = 0,
  parameter int DIM3 = 0,
  parameter int ALGO = 0
) (
  input  logic [CW-1:0] dx,
  input  logic [CW-1:0] dy,
  input  logic [CW-1:0] dz,
  input  logic [3:0]    cong,
  output port_t         port
);

  localparam logic [CW-1:0] MX = CW'(MY_X);
  localparam logic [CW-1:0] MY = CW'(MY_Y);
  localparam logic [CW-1:0] MZ = CW'(MY_Z);

  port_t x_port;
  port_t y_port;
  port_t z_port;
  port_t xy_port;
  port_t yx_port;
  logic  y_cong;
  logic  inputs_unused;

  // Depending on the configuration some of cong/dz never reach the port
  assign inputs_unused = ^{cong, dz};

  always_comb begin
    x_port  = PORT_NONE;
    y_port  = PORT_NONE;
    z_port  = PORT_NONE;
    xy_port = PORT_LOCAL;
    yx_port = PORT_LOCAL;
    y_cong  = 1'b0;
    port    = PORT_LOCAL;

    if (dx > MX)      x_port = PORT_EAST;
    else if (dx < MX) x_port = PORT_WEST;
    if (dy > MY)      y_port = PORT_NORTH;
    else if (dy < MY) y_port = PORT_SOUTH;
    if (DIM3 != 0) begin
      if (dz > MZ)      z_port = PORT_UP;
      else if (dz < MZ) z_port = PORT_DOWN;
    end

    if (x_port != PORT_NONE)      xy_port = x_port;
    else if (y_port != PORT_NONE) xy_port = y_port;
    else if (z_port != PORT_NONE) xy_port = z_port;

    if (y_port != PORT_NONE)      yx_port = y_port;
    else if (x_port != PORT_NONE) yx_port = x_port;
    else if (z_port != PORT_NONE) yx_port = z_port;

    y_cong = (y_port == PORT_NORTH) ? cong[CONG_N] : cong[CONG_S];

    case (ALGO)
      ALGO_YX: port = yx_port;
      // West-first: only the east+north/south pair is adaptive; east wins ties
      ALGO_WF: begin
        if (x_port == PORT_EAST && y_port != PORT_NONE)
          port = (cong[CONG_E] && !y_cong) ? y_port : PORT_EAST;
        else
          port = xy_port;
      end
      default: port = xy_port;
    endcase
  end

endmodule

// File: rtl/rcu_param.sv
// Per-input-port routing computation unit: routes the header flit and holds
// the selected output port until the packet's tail flit is forwarded.
module rcu_param
  import noc_pkg::*;
#(
  parameter int FW     = 39,
  parameter int CW     = 4,
  parameter int DX_MSB = 25,
  parameter int DY_MSB = 21,
  parameter int DZ_MSB = 17,
  parameter int MY_X   = 0,
  parameter int MY_Y   = 0,
  parameter int MY_Z   = 0,
  parameter int DIM3   = 0,
  parameter int ALGO   = 0
) (
  input  logic       clk_t,
  input  logic       rst_t,
  rcu_param_if.slave bus
);

  rcu_state_t state;
  port_t      op_r;
  port_t      route_port;
  logic       op_valid_r;
  logic       err_r;
  flit_type_t ftype;
  logic       flit_unused;

  assign ftype       = bus.flit[FW -: 2];
  assign flit_unused = ^bus.flit;

  rcu_route_calc #(
    .CW   (CW),
    .MY_X (MY_X),
    .MY_Y (MY_Y),
    .MY_Z (MY_Z),
    .DIM3 (DIM3),
    .ALGO (ALGO)
  ) u_route (
    .dx   (bus.flit[DX_MSB -: CW]),
    .dy   (bus.flit[DY_MSB -: CW]),
    .dz   (bus.flit[DZ_MSB -: CW]),
    .cong (bus.cong),
    .port (route_port)
  );

  // op is only loaded from a header seen in IDLE, so congestion changes
  // mid-packet can never re-route it
  always_ff @(posedge clk_t or posedge rst_t) begin
    if (rst_t) begin
      state      <= ST_IDLE;
      op_r       <= PORT_NONE;
      op_valid_r <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.flit_valid) begin
            if (ftype == FLIT_HEAD) begin
              op_r       <= route_port;
              op_valid_r <= 1'b1;
              state      <= ST_HEAD;
            end else begin
              err_r <= 1'b1;
            end
          end
        end
        ST_HEAD: begin
          if (bus.flit_valid) begin
            if (ftype != FLIT_HEAD)  err_r <= 1'b1;
            else if (bus.flit_ack)   state <= ST_BODY;
          end
        end
        ST_BODY: begin
          if (bus.flit_valid) begin
            if (ftype == FLIT_TAIL) begin
              if (bus.flit_ack) begin
                op_valid_r <= 1'b0;
                state      <= ST_IDLE;
              end
            end else if (ftype != FLIT_BODY) begin
              err_r <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.op       = op_r;
  assign bus.op_valid = op_valid_r;
  assign bus.err      = err_r;

endmodule

// File: tb/tb_rcu_param.sv
// Testbench for rcu_param: four differently configured instances share one
// flit stream and are compared with a packet-level reference model.
module tb_rcu_param;

  localparam logic [2:0] P_NONE  = 3'b000;
  localparam logic [2:0] P_LOCAL = 3'b001;
  localparam logic [2:0] P_EAST  = 3'b010;
  localparam logic [2:0] P_WEST  = 3'b011;
  localparam logic [2:0] P_NORTH = 3'b100;
  localparam logic [2:0] P_SOUTH = 3'b101;
  localparam logic [2:0] P_UP    = 3'b110;
  localparam logic [2:0] P_DOWN  = 3'b111;

  localparam logic [1:0] T_HEAD = 2'b11;
  localparam logic [1:0] T_BODY = 2'b10;
  localparam logic [1:0] T_TAIL = 2'b01;
  localparam logic [1:0] T_BAD  = 2'b00;

  // Instance configurations: 0 = XY (2,2), 1 = YX (2,2), 2 = west-first (1,1), 3 = XY 3D (2,2,1)
  int my_x [4] = '{2, 2, 1, 2};
  int my_y [4] = '{2, 2, 1, 2};
  int my_z [4] = '{0, 0, 0, 1};
  int algo [4] = '{0, 1, 2, 0};
  int dim3 [4] = '{0, 0, 0, 1};

  logic        clk_t = 1'b0;
  logic        rst_t = 1'b0;
  logic [39:0] flit = '0;
  logic        flit_valid = 1'b0;
  logic        flit_ack = 1'b0;
  logic [3:0]  cong = '0;

  logic [2:0] op_o [4];
  logic       ov_o [4];
  logic       err_o [4];

  logic [2:0] exp_op [4];
  logic       exp_ov [4];
  logic       exp_err [4];
  logic       m_active [4];
  int         m_fwd [4];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_t = ~clk_t;

  rcu_param_if #(.FW(39)) bus0 ();
  rcu_param_if #(.FW(39)) bus1 ();
  rcu_param_if #(.FW(39)) bus2 ();
  rcu_param_if #(.FW(39)) bus3 ();

  assign bus0.flit = flit; assign bus0.flit_valid = flit_valid; assign bus0.flit_ack = flit_ack; assign bus0.cong = cong;
  assign bus1.flit = flit; assign bus1.flit_valid = flit_valid; assign bus1.flit_ack = flit_ack; assign bus1.cong = cong;
  assign bus2.flit = flit; assign bus2.flit_valid = flit_valid; assign bus2.flit_ack = flit_ack; assign bus2.cong = cong;
  assign bus3.flit = flit; assign bus3.flit_valid = flit_valid; assign bus3.flit_ack = flit_ack; assign bus3.cong = cong;

  assign op_o[0] = bus0.op; assign ov_o[0] = bus0.op_valid; assign err_o[0] = bus0.err;
  assign op_o[1] = bus1.op; assign ov_o[1] = bus1.op_valid; assign err_o[1] = bus1.err;
  assign op_o[2] = bus2.op; assign ov_o[2] = bus2.op_valid; assign err_o[2] = bus2.err;
  assign op_o[3] = bus3.op; assign ov_o[3] = bus3.op_valid; assign err_o[3] = bus3.err;

  rcu_param #(.MY_X(2), .MY_Y(2), .MY_Z(0), .DIM3(0), .ALGO(0)) dut_xy (.clk_t(clk_t), .rst_t(rst_t), .bus(bus0));
  rcu_param #(.MY_X(2), .MY_Y(2), .MY_Z(0), .DIM3(0), .ALGO(1)) dut_yx (.clk_t(clk_t), .rst_t(rst_t), .bus(bus1));
  rcu_param #(.MY_X(1), .MY_Y(1), .MY_Z(0), .DIM3(0), .ALGO(2)) dut_wf (.clk_t(clk_t), .rst_t(rst_t), .bus(bus2));
  rcu_param #(.MY_X(2), .MY_Y(2), .MY_Z(1), .DIM3(1), .ALGO(0)) dut_3d (.clk_t(clk_t), .rst_t(rst_t), .bus(bus3));

  // Reference route: signed distances per axis, dimension order, then the west-first override
  function automatic logic [2:0] model_route(input int k, input int dx, input int dy, input int dz,
                                             input logic [3:0] cg);
    int ddx = dx - my_x[k];
    int ddy = dy - my_y[k];
    int ddz = dz - my_z[k];
    logic [2:0] xd, yd, zd, first, second, best;
    xd = (ddx > 0) ? P_EAST : ((ddx < 0) ? P_WEST : P_NONE);
    yd = (ddy > 0) ? P_NORTH : ((ddy < 0) ? P_SOUTH : P_NONE);
    zd = (dim3[k] == 0 || ddz == 0) ? P_NONE : ((ddz > 0) ? P_UP : P_DOWN);
    first  = (algo[k] == 1) ? yd : xd;
    second = (algo[k] == 1) ? xd : yd;
    if (first != P_NONE)       best = first;
    else if (second != P_NONE) best = second;
    else if (zd != P_NONE)     best = zd;
    else                       best = P_LOCAL;
    if (algo[k] == 2 && ddx > 0 && ddy != 0)
      best = (cg[0] && !((ddy > 0) ? cg[2] : cg[3])) ? yd : P_EAST;
    return best;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) begin
      exp_op[k] = P_NONE; exp_ov[k] = 1'b0; exp_err[k] = 1'b0;
      m_active[k] = 1'b0; m_fwd[k] = 0;
    end
  endfunction

  // Packet-level view: m_fwd counts flits of the current packet already forwarded
  function automatic void model_step(input logic v, input logic [1:0] t, input int dx, input int dy,
                                     input int dz, input logic [3:0] cg, input logic a);
    for (int k = 0; k < 4; k++) begin
      if (!v) continue;
      if (!m_active[k]) begin
        if (t == T_HEAD) begin
          exp_op[k] = model_route(k, dx, dy, dz, cg);
          exp_ov[k] = 1'b1; m_active[k] = 1'b1; m_fwd[k] = 0;
        end else exp_err[k] = 1'b1;
      end else if (m_fwd[k] == 0) begin
        if (t != T_HEAD) exp_err[k] = 1'b1;
        else if (a) m_fwd[k] = 1;
      end else begin
        if (t == T_HEAD || t == T_BAD) exp_err[k] = 1'b1;
        else if (a && t == T_BODY) m_fwd[k] = m_fwd[k] + 1;
        else if (a && t == T_TAIL) begin m_active[k] = 1'b0; exp_ov[k] = 1'b0; end
      end
    end
  endfunction

  task automatic applyStimulus(input logic v, input logic [1:0] t, input int dx, input int dy,
                               input int dz, input logic [3:0] cg, input logic a);
    @(negedge clk_t);
    flit = {8'($urandom), 32'($urandom)};
    flit[39:38] = t;
    flit[25:22] = 4'(dx);
    flit[21:18] = 4'(dy);
    flit[17:14] = 4'(dz);
    flit_valid = v; flit_ack = a; cong = cg;
    @(posedge clk_t);
    model_step(v, t, dx, dy, dz, cg, a);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk_t);
    rst_t = 1'b1; flit_valid = 1'b0; flit_ack = 1'b0;
    model_reset();
    @(negedge clk_t);
    rst_t = 1'b0;
  endtask

  task automatic finish_packet();
    applyStimulus(1, T_HEAD, 0, 0, 0, 4'hf, 1);
    applyStimulus(1, T_TAIL, 0, 0, 0, 4'hf, 1);
  endtask

  task automatic test_reset();
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({op_o[k], ov_o[k], err_o[k]} !== {P_NONE, 2'b00}) begin
        n_fail++; $display("[TB] FAIL reset_state inst%0d: got op=%b ov=%b err=%b, want 000/0/0", k, op_o[k], ov_o[k], err_o[k]);
      end
    end
    applyStimulus(1, T_BODY, 0, 0, 0, 0, 0);
    applyStimulus(1, T_HEAD, 3, 0, 0, 0, 0);
    applyStimulus(1, T_HEAD, 3, 0, 0, 0, 1);
    n_checks++;
    if ({ov_o[0], err_o[0]} !== 2'b11) begin
      n_fail++; $display("[TB] FAIL pre_reset inst0: got ov=%b err=%b, want 1/1", ov_o[0], err_o[0]);
    end
    @(negedge clk_t);
    #2 rst_t = 1'b1;
    model_reset();
    #1;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({op_o[k], ov_o[k], err_o[k]} !== {P_NONE, 2'b00}) begin
        n_fail++; $display("[TB] FAIL async_reset inst%0d: got op=%b ov=%b err=%b, want 000/0/0", k, op_o[k], ov_o[k], err_o[k]);
      end
    end
    @(negedge clk_t);
    rst_t = 1'b0;
    flit_valid = 1'b0;
  endtask

  task automatic test_xy_packet();
    apply_reset();
    applyStimulus(0, T_HEAD, 3, 0, 0, 0, 0);
    n_checks++;
    if (ov_o[0] !== 1'b0) begin
      n_fail++; $display("[TB] FAIL xy_idle_ov: got %b, want 0", ov_o[0]);
    end
    applyStimulus(1, T_HEAD, 3, 0, 0, 0, 0);
    n_checks++;
    if ({op_o[0], ov_o[0]} !== {P_EAST, 1'b1}) begin
      n_fail++; $display("[TB] FAIL xy_head_route: got op=%b ov=%b, want 010/1", op_o[0], ov_o[0]);
    end
    n_checks++;
    if (op_o[1] !== P_SOUTH) begin
      n_fail++; $display("[TB] FAIL yx_head_route: got %b, want 101", op_o[1]);
    end
    applyStimulus(1, T_HEAD, 3, 0, 0, 4'hf, 1);
    applyStimulus(1, T_BODY, 0, 0, 0, 4'hf, 1);
    applyStimulus(1, T_BODY, 0, 0, 0, 4'hf, 1);
    n_checks++;
    if ({op_o[0], ov_o[0]} !== {P_EAST, 1'b1}) begin
      n_fail++; $display("[TB] FAIL xy_body_hold: got op=%b ov=%b, want 010/1", op_o[0], ov_o[0]);
    end
    applyStimulus(1, T_TAIL, 0, 0, 0, 0, 1);
    n_checks++;
    if ({op_o[0], ov_o[0]} !== {P_EAST, 1'b0}) begin
      n_fail++; $display("[TB] FAIL xy_tail_release: got op=%b ov=%b, want 010/0", op_o[0], ov_o[0]);
    end
  endtask

  task automatic test_back_to_back();
    applyStimulus(1, T_HEAD, 2, 2, 0, 0, 0);
    n_checks++;
    if ({op_o[1], ov_o[1]} !== {P_LOCAL, 1'b1}) begin
      n_fail++; $display("[TB] FAIL yx_second_pkt: got op=%b ov=%b, want 001/1", op_o[1], ov_o[1]);
    end
    finish_packet();
  endtask

  task automatic test_west_first();
    apply_reset();
    applyStimulus(1, T_HEAD, 3, 3, 0, 4'b0001, 0);
    n_checks++;
    if (op_o[2] !== P_NORTH) begin
      n_fail++; $display("[TB] FAIL wf_east_congested: got %b, want 100", op_o[2]);
    end
    finish_packet();
    applyStimulus(1, T_HEAD, 3, 3, 0, 4'b0000, 0);
    n_checks++;
    if (op_o[2] !== P_EAST) begin
      n_fail++; $display("[TB] FAIL wf_no_congestion: got %b, want 010", op_o[2]);
    end
    applyStimulus(1, T_HEAD, 3, 3, 0, 4'b0001, 1);
    n_checks++;
    if (op_o[2] !== P_EAST) begin
      n_fail++; $display("[TB] FAIL wf_frozen_op: got %b, want 010", op_o[2]);
    end
    applyStimulus(1, T_TAIL, 0, 0, 0, 0, 1);
    applyStimulus(1, T_HEAD, 0, 3, 0, 4'b0010, 0);
    n_checks++;
    if (op_o[2] !== P_WEST) begin
      n_fail++; $display("[TB] FAIL wf_west: got %b, want 011", op_o[2]);
    end
    finish_packet();
  endtask

  task automatic test_dim3();
    logic [2:0] want [3] = '{P_UP, P_DOWN, P_LOCAL};
    int         dz   [3] = '{5, 0, 1};
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, T_HEAD, 2, 2, dz[i], 0, 0);
      n_checks++;
      if (op_o[3] !== want[i]) begin
        n_fail++; $display("[TB] FAIL dim3_dz%0d: got %b, want %b", dz[i], op_o[3], want[i]);
      end
      finish_packet();
    end
  endtask

  task automatic test_errors();
    apply_reset();
    applyStimulus(1, T_BODY, 0, 0, 0, 0, 1);
    n_checks++;
    if ({ov_o[0], err_o[0]} !== 2'b01) begin
      n_fail++; $display("[TB] FAIL err_body_in_idle: got ov=%b err=%b, want 0/1", ov_o[0], err_o[0]);
    end
    applyStimulus(1, T_HEAD, 3, 0, 0, 0, 0);
    applyStimulus(1, T_HEAD, 3, 0, 0, 0, 1);
    applyStimulus(1, T_HEAD, 0, 0, 0, 0, 0);
    n_checks++;
    if ({op_o[0], ov_o[0], err_o[0]} !== {P_EAST, 2'b11}) begin
      n_fail++; $display("[TB] FAIL err_head_in_body: got op=%b ov=%b err=%b, want 010/1/1", op_o[0], ov_o[0], err_o[0]);
    end
    applyStimulus(1, T_BODY, 0, 0, 0, 0, 1);
    applyStimulus(1, T_TAIL, 0, 0, 0, 0, 1);
    n_checks++;
    if ({ov_o[0], err_o[0]} !== 2'b01) begin
      n_fail++; $display("[TB] FAIL err_pkt_continues: got ov=%b err=%b, want 0/1", ov_o[0], err_o[0]);
    end
  endtask

  task automatic test_random();
    logic [1:0] t;
    int r;
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 15);
      t = (r < 4) ? T_HEAD : (r < 10) ? T_BODY : (r < 14) ? T_TAIL : T_BAD;
      applyStimulus(($urandom_range(0, 9) < 7), t, $urandom_range(0, 4), $urandom_range(0, 4),
                    $urandom_range(0, 3), 4'($urandom), 1'($urandom));
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if ({op_o[k], ov_o[k], err_o[k]} !== {exp_op[k], exp_ov[k], exp_err[k]}) begin
          n_fail++;
          $display("[TB] FAIL random_cycle%0d inst%0d: got op=%b ov=%b err=%b, want op=%b ov=%b err=%b",
                   n, k, op_o[k], ov_o[k], err_o[k], exp_op[k], exp_ov[k], exp_err[k]);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    rst_t = 1'b1;
    #12 rst_t = 1'b0;
    test_reset();
    test_xy_packet();
    test_back_to_back();
    test_west_first();
    test_dim3();
    test_errors();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
